// File: rtl/score_pkg.sv
// Shared definitions for the two-player score controller: state encoding,
// default game/display parameters and a small score helper.
package score_pkg;

    // Default score that ends a game (legal range 1..15).
    localparam int WIN_SCORE_DEF = 9;

    // Default number of clk cycles each display digit slot is shown.
    localparam int MUX_DIV_DEF = 1000;

    // Width of one player's binary score.
    localparam int SCORE_W = 4;

    // Game state encoding; the numeric values are visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } state_t;

    // Player indices into the two-bit request/grant vectors.
    localparam int PLAYER_A = 0;
    localparam int PLAYER_B = 1;

    // True when crediting one more point to 'score' reaches 'target'.
    function automatic logic hits_win(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] target
    );
        return (score + {{(SCORE_W-1){1'b0}}, 1'b1}) == target;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. At most one grant per cycle; when both
// request, the one not served last wins. The pointer favours requester 0
// out of reset and only moves when a grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr = 0: requester 0 has priority on a tie; ptr = 1: requester 1 has it.
    logic ptr;

    // Pick a winner from the current requests; nothing is granted unless enabled.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Hand priority to the other requester after every issued grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/score_ctrl.sv
// Two-player score controller. Point buttons are edge-detected into pending
// requests, a round-robin arbiter credits at most one point per cycle, and the
// game FSM moves IDLE -> PLAY -> WIN. A free-running divider alternates a
// single display digit between the two scores.
//
// Handshake: pt_a/pt_b are levels; a 0->1 transition seen in PLAY is one point
// request. A request is held pending until granted; gnt_x is a one-cycle pulse
// that coincides with the score increment. Requests arriving while the same
// player is still pending are merged into the existing one.
module score_ctrl
    import score_pkg::*;
#(
    parameter int WIN_SCORE = WIN_SCORE_DEF,
    parameter int MUX_DIV   = MUX_DIV_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               clr,
    input  logic               pt_a,
    input  logic               pt_b,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               gnt_a,
    output logic               gnt_b,
    output logic               win_a,
    output logic               win_b,
    output logic [1:0]         state,
    output logic               digit_sel,
    output logic [SCORE_W-1:0] seg_val
);

    localparam logic [SCORE_W-1:0] WIN_L = SCORE_W'(WIN_SCORE);
    localparam int CNT_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUX_DIV - 1);

    // Game registers.
    state_t             state_q;
    logic [SCORE_W-1:0] score_a_q;
    logic [SCORE_W-1:0] score_b_q;
    logic               pend_a_q;
    logic               pend_b_q;
    logic               gnt_a_q;
    logic               gnt_b_q;
    logic               win_a_q;
    logic               win_b_q;

    // Button history for edge detection.
    logic               prev_a_q;
    logic               prev_b_q;

    // Display divider.
    logic [CNT_W-1:0]   cnt_q;
    logic               sel_q;

    // Derived per-cycle signals.
    logic               rise_a;
    logic               rise_b;
    logic               arb_en;
    logic [1:0]         arb_req;
    logic [1:0]         arb_gnt;

    // A rising button edge is the current level high with the stored level low.
    assign rise_a = pt_a & ~prev_a_q;
    assign rise_b = pt_b & ~prev_b_q;

    // Points are only credited while playing, enabled, and not being cleared.
    assign arb_en  = ena & (state_q == ST_PLAY) & ~clr;
    assign arb_req = {pend_b_q, pend_a_q};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    // Track the previous button levels; frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
        end else if (ena) begin
            prev_a_q <= pt_a;
            prev_b_q <= pt_b;
        end
    end

    // Game FSM with scores, pending requests, grant pulses and win flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            score_a_q <= '0;
            score_b_q <= '0;
            pend_a_q  <= 1'b0;
            pend_b_q  <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            win_a_q   <= 1'b0;
            win_b_q   <= 1'b0;
        end else if (ena) begin
            // Grant pulses last exactly one enabled cycle.
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            if (clr) begin
                // Abort wins over everything else happening this cycle.
                state_q   <= ST_IDLE;
                score_a_q <= '0;
                score_b_q <= '0;
                pend_a_q  <= 1'b0;
                pend_b_q  <= 1'b0;
                win_a_q   <= 1'b0;
                win_b_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        pend_a_q <= 1'b0;
                        pend_b_q <= 1'b0;
                        if (start) begin
                            state_q <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        // Granted request is consumed; a same-cycle edge re-arms it,
                        // an edge on an ungranted pending request merges into it.
                        pend_a_q <= (pend_a_q & ~arb_gnt[PLAYER_A]) | rise_a;
                        pend_b_q <= (pend_b_q & ~arb_gnt[PLAYER_B]) | rise_b;
                        if (arb_gnt[PLAYER_A]) begin
                            score_a_q <= score_a_q + 1'b1;
                            gnt_a_q   <= 1'b1;
                            if (hits_win(score_a_q, WIN_L)) begin
                                state_q  <= ST_WIN;
                                win_a_q  <= 1'b1;
                                pend_a_q <= 1'b0;
                                pend_b_q <= 1'b0;
                            end
                        end
                        if (arb_gnt[PLAYER_B]) begin
                            score_b_q <= score_b_q + 1'b1;
                            gnt_b_q   <= 1'b1;
                            if (hits_win(score_b_q, WIN_L)) begin
                                state_q  <= ST_WIN;
                                win_b_q  <= 1'b1;
                                pend_a_q <= 1'b0;
                                pend_b_q <= 1'b0;
                            end
                        end
                    end
                    ST_WIN: begin
                        // Game over: button activity is ignored until clr.
                        pend_a_q <= 1'b0;
                        pend_b_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        pend_a_q <= 1'b0;
                        pend_b_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Display slot divider: runs in every state, toggles the slot on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else if (ena) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                sel_q <= ~sel_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Output mapping; grant pulses are suppressed while the design is disabled.
    assign score_a   = score_a_q;
    assign score_b   = score_b_q;
    assign gnt_a     = gnt_a_q & ena;
    assign gnt_b     = gnt_b_q & ena;
    assign win_a     = win_a_q;
    assign win_b     = win_b_q;
    assign state     = state_q;
    assign digit_sel = sel_q;
    assign seg_val   = sel_q ? score_b_q : score_a_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios with literal expectations plus a
// cycle-level behavioural model compared against the outputs every cycle.
module tb_score_ctrl;

    localparam int WIN = 9;
    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       clr;
    logic       pt_a;
    logic       pt_b;
    logic [3:0] score_a;
    logic [3:0] score_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       win_a;
    logic       win_b;
    logic [1:0] state;
    logic       digit_sel;
    logic [3:0] seg_val;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    score_ctrl #(.WIN_SCORE(WIN), .MUX_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .clr       (clr),
        .pt_a      (pt_a),
        .pt_b      (pt_b),
        .score_a   (score_a),
        .score_b   (score_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .win_a     (win_a),
        .win_b     (win_b),
        .state     (state),
        .digit_sel (digit_sel),
        .seg_val   (seg_val)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game described per player, display slot derived
    // from the number of enabled cycles since reset.
    int m_state = 0;
    int m_score[2] = '{0, 0};
    int m_pend[2]  = '{0, 0};
    int m_prev[2]  = '{0, 0};
    int m_gnt[2]   = '{0, 0};
    int m_win[2]   = '{0, 0};
    int m_last     = 1;   // player served most recently; 1 means A goes first
    int m_ticks    = 0;
    int m_rise[2];
    int m_in[2];
    int m_who;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_score = '{0, 0};
            m_pend  = '{0, 0};
            m_prev  = '{0, 0};
            m_gnt   = '{0, 0};
            m_win   = '{0, 0};
            m_last  = 1;
            m_ticks = 0;
        end else if (ena) begin
            m_in[0] = int'(pt_a);
            m_in[1] = int'(pt_b);
            for (int p = 0; p < 2; p++) begin
                m_rise[p] = (m_in[p] == 1 && m_prev[p] == 0) ? 1 : 0;
                m_prev[p] = m_in[p];
            end
            m_gnt = '{0, 0};
            m_ticks++;
            if (clr) begin
                m_state = 0;
                m_score = '{0, 0};
                m_pend  = '{0, 0};
                m_win   = '{0, 0};
            end else if (m_state == 0) begin
                if (start) m_state = 1;
            end else if (m_state == 1) begin
                m_who = -1;
                if (m_pend[0] == 1 && m_pend[1] == 1) m_who = 1 - m_last;
                else if (m_pend[0] == 1) m_who = 0;
                else if (m_pend[1] == 1) m_who = 1;
                if (m_who >= 0) begin
                    m_pend[m_who] = 0;
                    m_score[m_who] = m_score[m_who] + 1;
                    m_gnt[m_who] = 1;
                    m_last = m_who;
                end
                for (int p = 0; p < 2; p++) if (m_rise[p] == 1) m_pend[p] = 1;
                if (m_who >= 0 && m_score[m_who] == WIN) begin
                    m_state = 2;
                    m_win[m_who] = 1;
                    m_pend = '{0, 0};
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    int exp_sel;
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            exp_sel = (m_ticks / DIV) % 2;
            cmp("m_state", int'(state), m_state);
            cmp("m_score_a", int'(score_a), m_score[0]);
            cmp("m_score_b", int'(score_b), m_score[1]);
            cmp("m_gnt_a", int'(gnt_a), m_gnt[0] & int'(ena));
            cmp("m_gnt_b", int'(gnt_b), m_gnt[1] & int'(ena));
            cmp("m_win_a", int'(win_a), m_win[0]);
            cmp("m_win_b", int'(win_b), m_win[1]);
            cmp("m_digit_sel", int'(digit_sel), exp_sel);
            cmp("m_seg_val", int'(seg_val), exp_sel == 1 ? m_score[1] : m_score[0]);
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_a();
        pt_a = 1'b1; step();
        pt_a = 1'b0; step();
    endtask

    task automatic pulse_b();
        pt_b = 1'b1; step();
        pt_b = 1'b0; step();
    endtask

    int prev_sel;
    int toggles;
    int n3;
    int n7;

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; clr = 1'b0; pt_a = 1'b0; pt_b = 1'b0;
        step(); step();
        cmp("rst_state", int'(state), 0);
        cmp("rst_score_a", int'(score_a), 0);
        cmp("rst_score_b", int'(score_b), 0);
        cmp("rst_gnt_a", int'(gnt_a), 0);
        cmp("rst_win_a", int'(win_a), 0);
        cmp("rst_digit_sel", int'(digit_sel), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Single uncontended point
        start = 1'b1; step(); start = 1'b0;
        cmp("t1_state_play", int'(state), 1);
        pt_a = 1'b1; step();
        cmp("t1_score_a_edge1", int'(score_a), 0);
        cmp("t1_gnt_a_edge1", int'(gnt_a), 0);
        pt_a = 1'b0; step();
        cmp("t1_score_a_edge2", int'(score_a), 1);
        cmp("t1_gnt_a_edge2", int'(gnt_a), 1);
        step();
        cmp("t1_gnt_a_once", int'(gnt_a), 0);
        cmp("t1_score_a_hold", int'(score_a), 1);

        // Mid-game reset between edges, then simultaneous points
        rst_n = 1'b0; #1;
        cmp("t2_async_score_a", int'(score_a), 0);
        cmp("t2_async_state", int'(state), 0);
        step(); rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        pt_a = 1'b1; pt_b = 1'b1; step();
        pt_a = 1'b0; pt_b = 1'b0; step();
        cmp("t2_gnt_a_first", int'(gnt_a), 1);
        cmp("t2_gnt_b_first", int'(gnt_b), 0);
        cmp("t2_score_a", int'(score_a), 1);
        cmp("t2_score_b_wait", int'(score_b), 0);
        step();
        cmp("t2_gnt_a_second", int'(gnt_a), 0);
        cmp("t2_gnt_b_second", int'(gnt_b), 1);
        cmp("t2_score_b", int'(score_b), 1);
        step();
        cmp("t2_gnt_b_done", int'(gnt_b), 0);

        // Play A to the winning score; late B request is discarded
        repeat (7) pulse_a();
        cmp("t3_score_a_8", int'(score_a), 8);
        cmp("t3_state_play", int'(state), 1);
        pt_a = 1'b1; step();
        pt_a = 1'b0; pt_b = 1'b1; step();
        cmp("t3_score_a_win", int'(score_a), 9);
        cmp("t3_state_win", int'(state), 2);
        cmp("t3_win_a", int'(win_a), 1);
        cmp("t3_win_b", int'(win_b), 0);
        pt_b = 1'b0; step();
        cmp("t3_score_b_disc", int'(score_b), 1);
        cmp("t3_gnt_b_disc", int'(gnt_b), 0);
        repeat (3) pulse_b();
        cmp("t3_score_b_frozen", int'(score_b), 1);
        cmp("t3_score_a_cap", int'(score_a), 9);
        cmp("t3_state_stays", int'(state), 2);

        // clr wins over a pending grant
        clr = 1'b1; step(); clr = 1'b0;
        cmp("t4_clr_state", int'(state), 0);
        cmp("t4_clr_win_a", int'(win_a), 0);
        cmp("t4_clr_score_a", int'(score_a), 0);
        start = 1'b1; step(); start = 1'b0;
        repeat (5) pulse_a();
        cmp("t4_score_a_5", int'(score_a), 5);
        pt_a = 1'b1; step();
        pt_a = 1'b0; clr = 1'b1; step(); clr = 1'b0;
        cmp("t4_state_idle", int'(state), 0);
        cmp("t4_score_a_0", int'(score_a), 0);
        cmp("t4_gnt_a_0", int'(gnt_a), 0);
        step();
        cmp("t4_gnt_a_after", int'(gnt_a), 0);
        cmp("t4_score_a_after", int'(score_a), 0);

        // Display multiplexing with scores 3 and 7
        start = 1'b1; step(); start = 1'b0;
        repeat (3) pulse_a();
        repeat (7) pulse_b();
        cmp("t5_score_a_3", int'(score_a), 3);
        cmp("t5_score_b_7", int'(score_b), 7);
        prev_sel = int'(digit_sel);
        toggles = 0; n3 = 0; n7 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (int'(digit_sel) != prev_sel) toggles++;
            prev_sel = int'(digit_sel);
            if (seg_val == 4'd3) n3++;
            if (seg_val == 4'd7) n7++;
        end
        cmp("t5_toggles", toggles, 4);
        cmp("t5_seg_3_count", n3, 8);
        cmp("t5_seg_7_count", n7, 8);

        // Async reset during PLAY, then disable behaviour
        rst_n = 1'b0; #1;
        cmp("t6_async_state", int'(state), 0);
        cmp("t6_async_score_b", int'(score_b), 0);
        cmp("t6_async_digit_sel", int'(digit_sel), 0);
        step(); rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        ena = 1'b0;
        pt_a = 1'b1; step(); step();
        pt_a = 1'b0; step(); step();
        ena = 1'b1; step(); step();
        cmp("t6_ena_no_point", int'(score_a), 0);
        cmp("t6_ena_state", int'(state), 1);
        pt_a = 1'b1; step();
        pt_a = 1'b0; step();
        cmp("t6_gnt_a_on", int'(gnt_a), 1);
        ena = 1'b0; #1;
        cmp("t6_gnt_a_gated", int'(gnt_a), 0);
        step();
        cmp("t6_score_a_held", int'(score_a), 1);
        ena = 1'b1; step();
        cmp("t6_gnt_a_cleared", int'(gnt_a), 0);
        cmp("t6_score_a_final", int'(score_a), 1);
        step();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
